// File: rtl/switch_pkg.sv
// Shared types and constants for the switch output-port datapath.
// Packet header carries the payload length in its low nibble.
package switch_pkg;

  localparam int N_IN      = 3;
  localparam int DATA_W    = 8;
  localparam int STALL_MAX = 64;
  localparam int LEN_LSB   = 0;
  localparam int LEN_W     = 4;
  localparam int IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: the first requester after 'last',
// wrapping around, with 'last' itself checked at lowest priority.
module rr_picker
  import switch_pkg::*;
#(
  parameter int N_REQ = N_IN
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    // Walk from lowest to highest priority so the nearest requester wins.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Packet-granular round-robin arbiter: grants one input FIFO per packet and
// streams header plus payload through a registered valid/ready stage.
module output_port_arbiter #(
  parameter int N_IN      = switch_pkg::N_IN,
  parameter int DATA_W    = switch_pkg::DATA_W,
  parameter int STALL_MAX = switch_pkg::STALL_MAX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN-1:0]        empty,
  input  logic [N_IN*DATA_W-1:0] fifo_q,
  output logic [N_IN-1:0]        rdreq,
  output logic [1:0]             sel,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   busy,
  output logic                   err
);

  localparam int CNT_W = $clog2(STALL_MAX);
  localparam int LEN_W = switch_pkg::LEN_W;

  switch_pkg::state_t state, state_next;

  logic [DATA_W-1:0] head;
  logic [LEN_W-1:0]  head_len;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  stall_cnt;
  logic [1:0]        last;
  logic [1:0]        gnt_idx;
  logic              gnt_valid;
  logic              empty_sel;
  logic              pop;
  logic              eop_now;
  logic              stall_hit;
  logic              abort;

  rr_picker #(.N_REQ(N_IN)) u_picker (
    .req      (~empty),
    .last     (last),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  assign busy      = (state != switch_pkg::IDLE);
  assign head      = fifo_q[sel*DATA_W +: DATA_W];
  assign head_len  = head[switch_pkg::LEN_LSB +: LEN_W];
  assign empty_sel = empty[sel];
  // Pop only into a free or draining output register; gated by reset so rdreq is quiet while held in reset.
  assign pop       = reset && busy && !empty_sel && (!out_valid || out_ready);
  assign stall_hit = busy && empty_sel && (stall_cnt == CNT_W'(STALL_MAX - 1));

  always_comb begin
    rdreq = '0;
    if (pop) rdreq[sel] = 1'b1;
  end

  always_comb begin
    state_next = state;
    abort      = 1'b0;
    eop_now    = 1'b0;
    unique case (state)
      switch_pkg::IDLE: begin
        if (gnt_valid) state_next = switch_pkg::HDR;
      end
      switch_pkg::HDR: begin
        eop_now = (head_len == '0);
        if (pop) begin
          state_next = eop_now ? switch_pkg::IDLE : switch_pkg::PAY;
        end else if (stall_hit) begin
          abort      = 1'b1;
          state_next = switch_pkg::IDLE;
        end
      end
      switch_pkg::PAY: begin
        eop_now = (remaining == LEN_W'(1));
        if (pop) begin
          if (eop_now) state_next = switch_pkg::IDLE;
        end else if (stall_hit) begin
          abort      = 1'b1;
          state_next = switch_pkg::IDLE;
        end
      end
      default: state_next = switch_pkg::IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!reset) state <= switch_pkg::IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel       <= '0;
      last      <= 2'(N_IN - 1);
      remaining <= '0;
      stall_cnt <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= abort;

      if (state == switch_pkg::IDLE && gnt_valid) begin
        sel  <= gnt_idx;
        last <= gnt_idx;
      end

      if (!busy || pop || abort) stall_cnt <= '0;
      else if (empty_sel)        stall_cnt <= stall_cnt + 1'b1;

      if (pop) begin
        remaining <= (state == switch_pkg::HDR) ? head_len : remaining - 1'b1;
        out_data  <= head;
        out_valid <= 1'b1;
        out_sop   <= (state == switch_pkg::HDR);
        out_eop   <= eop_now;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Round-robin, packet-granular arbiter that shares one switch output link among the three input FIFOs of the VGA_LED switch datapath. It watches the FIFO empty flags and grants one input at a time. It drives that FIFO's `rdreq` and the output mux select, and streams the granted packet (header plus payload) through a registered valid/ready output stage. It sits between the input FIFOs and the output port logic, replacing ad-hoc `rdreq`/`sel` sequencing.

## Interface
Parameters:
- `N_IN`, 3: number of input FIFOs (requesters).
- `DATA_W`, 8: FIFO and link data width.
- `STALL_MAX`, 64: cycles a granted FIFO may stay empty mid-packet before abort.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `empty`, in, N_IN: empty flags of the show-ahead FIFOs. Bit i is FIFO i.
- `fifo_q`, in, N_IN*DATA_W: FIFO head data. Byte i is `[i*DATA_W +: DATA_W]`. It is valid whenever `empty[i]`=0.
- `rdreq`, out, N_IN: one-hot pop strobe.
- `sel`, out, 2: index of the currently granted FIFO, used as the mux select.
- `out_data`, out, DATA_W: registered output byte.
- `out_valid`, out, 1: `out_data` holds a byte.
- `out_ready`, in, 1: downstream accepts; a transfer occurs when `out_valid` and `out_ready` are both high.
- `out_sop`, out, 1: qualifies `out_data` as the header byte.
- `out_eop`, out, 1: qualifies `out_data` as the last byte of the packet.
- `busy`, out, 1: the FSM is not in IDLE.
- `err`, out, 1: one-cycle pulse when a packet is aborted on stall timeout.

## Operation
- Packet format:
  - Byte 0 is the header. `header[3:0]` is the payload length L (0–15). `header[7:4]` is passed through untouched.
  - The packet is 1+L bytes.
- The FSM has three states: IDLE, HDR and PAY.
- IDLE:
  - If any `empty[i]`=0, grant the first non-empty input in the order `last+1`, `last+2`, `last` (mod N_IN).
  - Register the grant into `sel` and update `last` to it. Go to HDR.
  - If all inputs are empty, stay in IDLE.
- Pop condition: `pop = busy && !empty[sel] && (!out_valid || out_ready)`. When `pop` is high, `rdreq[sel]`=1; all other `rdreq` bits are always 0.
- HDR, on pop:
  - Load `remaining = fifo_q[sel][3:0]` and set `out_sop`=1.
  - If L=0, also set `out_eop`=1 and go to IDLE. Otherwise go to PAY.
- PAY, on pop:
  - Decrement `remaining`.
  - When `remaining`=1 at the pop, set `out_eop`=1 and go to IDLE.
- A popped byte loads `out_data` and sets `out_valid`=1. If there is no pop and `out_ready`=1, `out_valid` clears.
- The grant is held for the whole packet. Other inputs are never served mid-packet, even when the granted FIFO is empty.
- Stall handling, in HDR or PAY:
  - `stall_cnt` increments each cycle that `empty[sel]`=1, and clears on pop.
  - When `stall_cnt` reaches STALL_MAX-1, pulse `err`, return to IDLE and clear `stall_cnt`.
  - No eop is emitted; downstream discards the partial packet on `err`.
- Reset (`reset`=0), applied at any time including mid-packet:
  - State goes to IDLE, `last` = N_IN-1 (so input 0 has first priority), and `sel`=0.
  - `out_valid`, `out_sop`, `out_eop`, `err`, `rdreq` and `out_data` all go to 0, and the counters clear.
  - A packet in flight is dropped; FIFO contents are not this block's concern.

## Timing
- Grant latency: a request seen in IDLE at cycle t gives `sel` valid and state HDR at t+1.
- The earliest `rdreq` is at t+1. The header appears on `out_data`/`out_valid` at t+2.
- Data latency is one cycle from `rdreq` to `out_data`.
- Throughput is 1 byte/cycle within a packet. There is exactly one idle grant cycle between packets.
- Backpressure: if `out_ready`=0 while `out_valid`=1, there is no pop and all outputs hold stable.
- `rdreq` is combinational from state, `empty`, `out_valid` and `out_ready`. All other outputs are registered.
- If `empty[sel]` rises in the same cycle as a pop, the pop is not issued.

## Structure
- Package `switch_pkg`:
  - `state_t` enum (IDLE, HDR, PAY).
  - Constants `N_IN`, `DATA_W`, `LEN_LSB`=0 and `LEN_W`=4.
- Sub-module `rr_picker`: combinational round-robin priority select. Inputs are the request vector and `last`. Outputs are `gnt_valid` and `gnt_idx`.
- `output_port_arbiter` holds the FSM, counters and output register.

## Test plan
- After reset, only FIFO1 is non-empty with header 0x02 and payload AA, BB, and `out_ready`=1 -> output is 02(sop), AA, BB(eop) on 3 consecutive cycles; `sel`=1; `err` stays 0.
- All three FIFOs each hold a header 0x00 packet -> grant order is 0, 1, 2, 0; each byte has sop=eop=1; there is one idle cycle between packets.
- Header 0x03 with `out_ready` toggling 1, 0, 1, 0 -> `out_data` is held while not ready; no byte is lost or duplicated; `rdreq` is never asserted while stalled.
- Granted FIFO goes empty after its header and FIFO2 is non-empty -> the grant stays on the original input; with STALL_MAX=64, `err` pulses 64 cycles after the last pop, then FIFO2 is granted.
- `reset`=0 mid-PAY -> the next cycle shows IDLE, all outputs 0, `last`=2; the first grant after reset goes to input 0 if it is non-empty.
- Header 0x0F (L=15) -> 16 bytes are transferred, with eop only on the 16th.
